// File: rtl/sprite_rom_arbiter_if.sv
// Requester/ROM bundle for the sprite ROM arbiter.
// slave modport faces the arbiter and master modport faces the requesters/ROM.
// req/addr are held by a requester until grant; rvalid/rdata return the palette index.
interface sprite_rom_arbiter_if #(
  parameter int N  = 2,
  parameter int AW = 19,
  parameter int DW = 8
);
  logic [N-1:0]    req;
  logic [N*AW-1:0] addr;
  logic [N-1:0]    grant;
  logic            flush;
  logic            rom_en;
  logic [AW-1:0]   rom_addr;
  logic [DW-1:0]   rom_data;
  logic [N-1:0]    rvalid;
  logic [DW-1:0]   rdata;
  logic            busy;

  modport slave (
    input  req, addr, flush, rom_data,
    output grant, rom_en, rom_addr, rvalid, rdata, busy
  );

  modport master (
    output req, addr, flush, rom_data,
    input  grant, rom_en, rom_addr, rvalid, rdata, busy
  );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Round-robin share of one sprite ROM read port between N pixel requesters.
// Latency: accept edge to rvalid is 1+ROM_LATENCY cycles; one accept per cycle.
// Backpressure: requesters hold req/addr until grant; flush blocks grants and drops in-flight reads.
// Ports: Clk, Reset_n (async active-low); bus.slave carries req/addr/grant/flush,
//        the ROM side rom_en/rom_addr/rom_data, and the return rvalid/rdata/busy.
module sprite_rom_arbiter #(
  parameter int N           = 2,
  parameter int AW          = 19,
  parameter int DW          = 8,
  parameter int ROM_LATENCY = 1
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  sprite_rom_arbiter_if.slave  bus
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int L  = ROM_LATENCY;

  logic [PW-1:0]        ptr;
  logic [N-1:0]         grant_c;
  logic [PW-1:0]        gnt_id;
  logic                 accept;
  logic [PW:0]          cand;

  // Stage 0 is aligned with rom_en; stages 1..L follow the ROM's internal
  // latency so that stage L is valid in the cycle rom_data is valid.
  logic [L:0]           tag_vld;
  logic [L:0][PW-1:0]   tag_id;

  logic                 rom_en_q;
  logic [AW-1:0]        rom_addr_q;
  logic [N-1:0]         rvalid_q;
  logic [DW-1:0]        rdata_q;
  logic                 busy_q;
  logic [N-1:0]         ret_onehot;

  // Scan ptr+1, ptr+2, ... with an explicit wrap so non-power-of-2 N works.
  always_comb begin
    grant_c = '0;
    gnt_id  = '0;
    accept  = 1'b0;
    cand    = '0;
    if (!bus.flush) begin
      for (int k = 1; k <= N; k++) begin
        cand = {1'b0, ptr} + (PW+1)'(k);
        if (cand >= (PW+1)'(N)) cand = cand - (PW+1)'(N);
        if (!accept && bus.req[cand[PW-1:0]]) begin
          accept = 1'b1;
          gnt_id = cand[PW-1:0];
        end
      end
    end
    if (accept) grant_c = {{(N-1){1'b0}}, 1'b1} << gnt_id;
  end

  assign ret_onehot = {{(N-1){1'b0}}, 1'b1} << tag_id[L];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr        <= PW'(N-1);
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      tag_vld    <= '0;
      tag_id     <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      // accept is already forced low by flush, so stage 0 and rom_en clear too.
      rom_en_q   <= accept;
      tag_vld[0] <= accept;
      tag_id[0]  <= gnt_id;
      if (accept) begin
        rom_addr_q <= bus.addr[gnt_id*AW +: AW];
        ptr        <= gnt_id;
      end
      for (int k = 1; k <= L; k++) begin
        tag_vld[k] <= tag_vld[k-1] & ~bus.flush;
        tag_id[k]  <= tag_id[k-1];
      end
      if (tag_vld[L] && !bus.flush) begin
        rvalid_q <= ret_onehot;
        rdata_q  <= bus.rom_data;
      end else begin
        rvalid_q <= '0;
      end
      // Post-edge view: rom_en and the tag stages as they will be after this edge.
      busy_q <= accept | ((|tag_vld[L-1:0]) & ~bus.flush);
    end
  end

  assign bus.grant    = grant_c;
  assign bus.rom_en   = rom_en_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.rvalid   = rvalid_q;
  assign bus.rdata    = rdata_q;
  assign bus.busy     = busy_q;
endmodule
